jk_bist: RTL and testbench

JK_BIST -- requirements
Module: jk_bist

---
 rtl/jk_bist_pkg.sv | 45 ++++
 rtl/jk_bist_ref_model.sv | 47 ++++
 rtl/jk_bist.sv | 177 +++++++++++++++++
 tb/tb_jk_bist.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/jk_bist_pkg.sv
// -----------------------------------------------------------------------------
// jk_bist_pkg
// Shared definitions for the JK flip-flop built-in self test:
//   - state_e     : controller FSM encoding
//   - step_e      : test step codes, STEP_RESET .. STEP_TOGGLE2
//   - STEP_DRIVE  : step -> {dut_rst, j, k} stimulus lookup
//   - CNT_W       : width of the mismatch cycle counter
// -----------------------------------------------------------------------------
package jk_bist_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    STEP_RESET   = 3'd0,
    STEP_HOLD    = 3'd1,
    STEP_SET     = 3'd2,
    STEP_CLEAR   = 3'd3,
    STEP_TOGGLE1 = 3'd4,
    STEP_TOGGLE2 = 3'd5
  } step_e;

  // Entries are {dut_rst, j, k}. Codes 6 and 7 are never issued; they are
  // padded with 0 so that any 3-bit index stays inside the table.
  localparam logic [7:0][2:0] STEP_DRIVE = {
    3'b000,  // 7 unused
    3'b000,  // 6 unused
    3'b011,  // STEP_TOGGLE2
    3'b011,  // STEP_TOGGLE1
    3'b001,  // STEP_CLEAR
    3'b010,  // STEP_SET
    3'b000,  // STEP_HOLD
    3'b100   // STEP_RESET
  };

  function automatic logic [2:0] step_drive(step_e s);
    return STEP_DRIVE[s];
  endfunction

endpackage

// File: rtl/jk_bist_ref_model.sv
// -----------------------------------------------------------------------------
// jk_ref_model
// Golden JK flip-flop that tracks the value the flip-flop under test should
// hold. It advances only when en=1, using the same stimulus that is being
// driven to the flip-flop under test.
// Ports:
//   clk  in  : clock
//   rst  in  : synchronous active-high reset, q -> 0
//   clr  in  : synchronous clear, q -> 0 (used on an accepted start)
//   en   in  : advance the model this edge
//   r    in  : reset stimulus seen by the flip-flop under test
//   j,k  in  : JK stimulus seen by the flip-flop under test
//   q    out : expected flip-flop value
// -----------------------------------------------------------------------------
module jk_ref_model (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic r,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= 1'b0;
    end else if (en) begin
      if (r) begin
        q_q <= 1'b0;
      end else begin
        unique case ({j, k})
          2'b10:   q_q <= 1'b1;
          2'b01:   q_q <= 1'b0;
          2'b11:   q_q <= ~q_q;
          default: q_q <= q_q;
        endcase
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bist.sv
// -----------------------------------------------------------------------------
// jk_bist
// Built-in self test for an external JK flip-flop. On start it drives six
// steps (RESET, HOLD, SET, CLEAR, TOGGLE, TOGGLE) of HOLD_CYCLES cycles each,
// compares the flip-flop output with a reference model at every edge except
// the one ending cycle 0, and stops at the first mismatch or after the last
// step.
// Parameter:
//   HOLD_CYCLES       : cycles per step, 1..15
// Configuration macro:
//   JK_BIST_CYCLE_CNT_EN : when defined, an 8-bit saturating cycle counter is
//                          built and fail_cycle reports the mismatch cycle;
//                          when undefined, fail_cycle is constant 0.
// Ports:
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   start      in  : one-cycle run request, ignored while busy
//   dut_q      in  : output of the flip-flop under test
//   j, k       out : JK stimulus (registered)
//   dut_rst    out : reset to the flip-flop under test (registered)
//   busy       out : sequence in progress
//   done       out : sequence finished, held until the next accepted start
//   pass       out : result, valid while done=1
//   fail_step  out : step of the first mismatch
//   fail_cycle out : cycle of the first mismatch
// -----------------------------------------------------------------------------
module jk_bist
  import jk_bist_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_q,
  output logic             j,
  output logic             k,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_step,
  output logic [CNT_W-1:0] fail_cycle
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e     state_q;
  step_e      step_q;
  step_e      step_d;
  logic [3:0] hold_q;
  logic       j_q, k_q, dut_rst_q;
  logic       busy_q, done_q, pass_q;
  logic [2:0] fail_step_q;
  logic       exp_q;

  logic start_ok;
  logic check_en;
  logic mismatch;
  logic step_end;
  logic last_cycle;

  // busy is high exactly in RUN, so RUN is the only state that blocks start.
  assign start_ok = start && (state_q != S_RUN);

  // The edge ending cycle 0 is the one that resets the flip-flop under test,
  // so its output is not meaningful yet; cycle 0 is always step 0, hold 0.
  assign check_en = (state_q == S_RUN) &&
                    !((step_q == STEP_RESET) && (hold_q == 4'd0));

  // NOTE: !== makes an X or Z on dut_q count as a mismatch in simulation;
  // a plain != would yield X and the if() would silently treat it as a match.
  assign mismatch   = check_en && (dut_q !== exp_q);
  assign step_end   = (hold_q == HOLD_LAST);
  assign last_cycle = step_end && (step_q == STEP_TOGGLE2);
  assign step_d     = step_e'(step_q + 3'd1);

  jk_ref_model u_ref (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (state_q == S_RUN),
    .r   (dut_rst_q),
    .j   (j_q),
    .k   (k_q),
    .q   (exp_q)
  );

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= STEP_RESET;
      hold_q      <= 4'd0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      dut_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_q                  <= S_RUN;
            step_q                   <= STEP_RESET;
            hold_q                   <= 4'd0;
            {dut_rst_q, j_q, k_q}    <= step_drive(STEP_RESET);
            busy_q                   <= 1'b1;
            done_q                   <= 1'b0;
            pass_q                   <= 1'b0;
            fail_step_q              <= 3'd0;
          end
        end
        S_RUN: begin
          if (mismatch || last_cycle) begin
            state_q               <= S_DONE;
            {dut_rst_q, j_q, k_q} <= 3'b000;
            busy_q                <= 1'b0;
            done_q                <= 1'b1;
            pass_q                <= !mismatch;
            if (mismatch) begin
              fail_step_q <= step_q;
            end
          end else if (step_end) begin
            step_q                <= step_d;
            hold_q                <= 4'd0;
            {dut_rst_q, j_q, k_q} <= step_drive(step_d);
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef JK_BIST_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] fail_cycle_q;

  // Counts RUN cycles from 0; saturates so fail_cycle can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q      <= '0;
      fail_cycle_q <= '0;
    end else if (start_ok) begin
      cycle_q      <= '0;
      fail_cycle_q <= '0;
    end else if (state_q == S_RUN) begin
      if (mismatch) begin
        fail_cycle_q <= cycle_q;
      end
      if (cycle_q != '1) begin
        cycle_q <= cycle_q + 1'b1;
      end
    end
  end

  assign fail_cycle = fail_cycle_q;
`else
  assign fail_cycle = '0;
`endif

  assign j         = j_q;
  assign k         = k_q;
  assign dut_rst   = dut_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;

endmodule

// File: tb/tb_jk_bist.sv
// -----------------------------------------------------------------------------
// tb_jk_bist
// Self-checking bench for jk_bist with HOLD_CYCLES=2. A behavioural JK
// flip-flop stands in for the device under test and can be switched into
// fault modes: 0 correct, 1 stuck at 0, 2 holds on j=k=1, 3 stuck at 1.
// Expected results are queued when a run is started and compared when the
// run finishes.
// -----------------------------------------------------------------------------
module tb_jk_bist;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_q;
  logic       j, k, dut_rst, busy, done, pass;
  logic [2:0] fail_step;
  logic [7:0] fail_cycle;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  logic ff_q = 1'b0;

  typedef struct {
    int   mode;
    logic pass;
    int   step;
    int   cyc;
    int   busy_n;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  always #5 clk = ~clk;

  jk_bist #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_q      (dut_q),
    .j          (j),
    .k          (k),
    .dut_rst    (dut_rst),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_step  (fail_step),
    .fail_cycle (fail_cycle)
  );

  // Flip-flop under test, with an optional "ignores toggle" fault.
  always @(posedge clk) begin
    if (dut_rst) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   if (mode != 2) ff_q <= ~ff_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (mode)
      1:       dut_q = 1'b0;
      3:       dut_q = 1'b1;
      default: dut_q = ff_q;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fc(input int c);
`ifdef JK_BIST_CYCLE_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // Expected {dut_rst, j, k} during RUN cycle n.
  function automatic logic [2:0] drive_at(input int n);
    case (n / HOLD)
      0:       return 3'b100;
      1:       return 3'b000;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  // Starts one run, optionally pulses a second start at cycle extra_at, waits
  // (bounded) for completion and compares the result against the scoreboard.
  task automatic run_one(input vec_t v, input int extra_at);
    vec_t e;
    int   n;
    mode = v.mode;
    sb.push_back(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (v.mode == 0) check($sformatf("drive_c%0d", n), {29'd0, dut_rst, j, k}, {29'd0, drive_at(n)});
      start = (n == extra_at);
      n++;
      tick();
    end
    start = 1'b0;
    e = sb.pop_front();
    check($sformatf("busy_cycles_m%0d", e.mode), n, e.busy_n);
    check("done", {31'd0, done}, 1);
    check("pass", {31'd0, pass}, {31'd0, e.pass});
    check("fail_step", {29'd0, fail_step}, e.step);
    check("fail_cycle", {24'd0, fail_cycle}, fc(e.cyc));
    check("idle_drive", {29'd0, dut_rst, j, k}, 0);
  endtask

  initial begin
    vecs[0] = '{mode: 0, pass: 1'b1, step: 0, cyc: 0,  busy_n: 12};
    vecs[1] = '{mode: 1, pass: 1'b0, step: 2, cyc: 5,  busy_n: 6};
    vecs[2] = '{mode: 2, pass: 1'b0, step: 4, cyc: 9,  busy_n: 10};
    vecs[3] = '{mode: 3, pass: 1'b0, step: 0, cyc: 1,  busy_n: 2};
    vecs[4] = '{mode: 0, pass: 1'b1, step: 0, cyc: 0,  busy_n: 12};

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_drive", {29'd0, dut_rst, j, k}, 0);
    check("rst_fail_step", {29'd0, fail_step}, 0);
    check("rst_fail_cycle", {24'd0, fail_cycle}, 0);

    // Table: back-to-back runs, each started from DONE after the first.
    for (int i = 0; i < 5; i++) run_one(vecs[i], -1);

    // done and pass are held while no start arrives.
    tick();
    tick();
    tick();
    check("done_held", {31'd0, done}, 1);
    check("pass_held", {31'd0, pass}, 1);

    // rst and start together: rst wins, start dropped.
    mode  = 0;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start_busy", {31'd0, busy}, 0);
    check("rst_start_done", {31'd0, done}, 0);

    // Reset during cycle 3 of RUN, then a clean rerun from cycle 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midrun_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_busy", {31'd0, busy}, 0);
    check("midrun_done", {31'd0, done}, 0);
    check("midrun_pass", {31'd0, pass}, 0);
    check("midrun_drive", {29'd0, dut_rst, j, k}, 0);
    run_one(vecs[0], -1);

    // Second start during cycle 4 is ignored; completion unchanged.
    run_one(vecs[0], 4);
    run_one(vecs[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
